cpu_bus_ctrl: RTL

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

---
 rtl/cpu_bus_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl
// Bridges a picorv32-style native memory request onto up to 16 slave ports.
// The top address byte selects a slave via per-slave prefix/mask pairs; slaves
// flagged firmware-only are refused while the CPU runs in application mode.
// Every access that fails (unmapped, protected, timed out) is logged in a
// sticky first-error register with a saturating error counter.
//
// Handshake: the CPU holds cpu_valid with a stable request until it sees
// cpu_ready, which is high for exactly one cycle per request. The request is
// captured on the first IDLE cycle with cpu_valid=1 and the CPU inputs are
// ignored until the response. On the slave side slv_cs[sel] stays high until
// slv_ready[sel] is seen on a rising edge (or the timeout expires); slave
// inputs are only looked at for the selected slave while in ACCESS.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   fw_app_mode         1 = application mode (firmware-only slaves blocked)
//   cpu_valid/addr/wdata/wstrb   CPU request
//   cpu_ready/cpu_rdata          CPU response (registered)
//   slv_cs              one-hot slave select, high only in ACCESS
//   slv_we/addr/wdata   latched request fields
//   slv_rdata/slv_ready per-slave read data (32 bits each) and ready
//   err_clr             clear the error log
//   err_valid/addr/cause/count   error log (cause 01 unmapped, 10 protected, 11 timeout)
//   dbg_state           current FSM state (0 IDLE, 1 ACCESS, 2 RESP)

module cpu_bus_ctrl #(
  parameter int                      NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*8-1:0] PREFIX_LIST    = 32'hff_c1_40_00,
  parameter logic [NUM_SLAVES*8-1:0] MASK_LIST      = 32'hff_ff_c0_c0,
  parameter logic [NUM_SLAVES-1:0]   FW_ONLY_MASK   = 4'b0000,
  parameter int                      TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fw_app_mode,
  input  logic                     cpu_valid,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  input  logic [3:0]               cpu_wstrb,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic [NUM_SLAVES-1:0]    slv_cs,
  output logic [3:0]               slv_we,
  output logic [31:0]              slv_addr,
  output logic [31:0]              slv_wdata,
  input  logic [NUM_SLAVES*32-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]    slv_ready,
  input  logic                     err_clr,
  output logic                     err_valid,
  output logic [31:0]              err_addr,
  output logic [1:0]               err_cause,
  output logic [7:0]               err_count,
  output logic [1:0]               dbg_state
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] CAUSE_UNMAPPED  = 2'b01;
  localparam logic [1:0] CAUSE_PROTECTED = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel;
  logic [15:0]      cnt;

  logic             dec_hit;
  logic             dec_blocked;
  logic [SEL_W-1:0] dec_idx;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic             timeout;

  logic             err_event;
  logic [1:0]       err_event_cause;
  logic [31:0]      err_event_addr;

  assign dbg_state = state;
  assign timeout   = (cnt == 16'(TIMEOUT_CYCLES));

  // Address decode. Walking from the highest index down lets the lowest
  // matching slave overwrite the others, so it wins on overlapping windows.
  always_comb begin
    dec_hit     = 1'b0;
    dec_blocked = 1'b0;
    dec_idx     = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_addr[31:24] & MASK_LIST[8*i +: 8]) == PREFIX_LIST[8*i +: 8]) begin
        dec_hit     = 1'b1;
        dec_blocked = FW_ONLY_MASK[i] & fw_app_mode;
        dec_idx     = SEL_W'(i);
      end
    end
  end

  // Only the latched slave's ready/rdata are visible to the FSM.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    slv_cs    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_rdata[32*i +: 32];
        slv_cs[i] = (state == ST_ACCESS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    err_event       = 1'b0;
    err_event_cause = 2'b00;
    err_event_addr  = slv_addr;
    case (state)
      ST_IDLE: begin
        if (cpu_valid) begin
          // Errors detected here use cpu_addr directly: slv_addr is only
          // being loaded on this same edge.
          if (!dec_hit) begin
            state_nxt       = ST_RESP;
            err_event       = 1'b1;
            err_event_cause = CAUSE_UNMAPPED;
            err_event_addr  = cpu_addr;
          end else if (dec_blocked) begin
            state_nxt       = ST_RESP;
            err_event       = 1'b1;
            err_event_cause = CAUSE_PROTECTED;
            err_event_addr  = cpu_addr;
          end else begin
            state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // A ready on the final allowed cycle still counts as success.
        if (sel_ready) begin
          state_nxt = ST_RESP;
        end else if (timeout) begin
          state_nxt       = ST_RESP;
          err_event       = 1'b1;
          err_event_cause = CAUSE_TIMEOUT;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latched request, access counter, response and error log.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel       <= '0;
      cnt       <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      slv_we    <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_cause <= '0;
      err_count <= '0;
    end else begin
      if (state == ST_IDLE && cpu_valid) begin
        slv_addr  <= cpu_addr;
        slv_wdata <= cpu_wdata;
        slv_we    <= cpu_wstrb;
        sel       <= dec_idx;
      end

      // First ACCESS cycle sees cnt=1, so cnt==TIMEOUT_CYCLES marks the last.
      if (state_nxt == ST_ACCESS) cnt <= (state == ST_ACCESS) ? cnt + 16'd1 : 16'd1;
      else                        cnt <= '0;

      cpu_ready <= (state_nxt == ST_RESP);
      cpu_rdata <= (state == ST_ACCESS && sel_ready) ? sel_rdata : 32'h0;

      // A new error on the same cycle as err_clr becomes the first error of
      // the freshly cleared log.
      if (err_event) begin
        if (err_clr || !err_valid) begin
          err_valid <= 1'b1;
          err_addr  <= err_event_addr;
          err_cause <= err_event_cause;
        end
        if (err_clr)                 err_count <= 8'd1;
        else if (err_count != 8'hff) err_count <= err_count + 8'd1;
      end else if (err_clr) begin
        err_valid <= 1'b0;
        err_addr  <= '0;
        err_cause <= '0;
        err_count <= '0;
      end
    end
  end

endmodule
